// File: rtl/ex_stage_pkg.sv
// Shared definitions for the MIPS32 execute stage: ALU op codes, widths and
// the divider state encoding.
package ex_stage_pkg;

    localparam int          DATA_WIDTH   = 32;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;

    localparam logic [7:0] ALU_NOP   = 8'b0000_0000;
    localparam logic [7:0] ALU_AND   = 8'b0010_0100;
    localparam logic [7:0] ALU_OR    = 8'b0010_0101;
    localparam logic [7:0] ALU_XOR   = 8'b0010_0110;
    localparam logic [7:0] ALU_NOR   = 8'b0010_0111;
    localparam logic [7:0] ALU_SLL   = 8'b0111_1100;
    localparam logic [7:0] ALU_SRL   = 8'b0000_0010;
    localparam logic [7:0] ALU_SRA   = 8'b0000_0011;
    localparam logic [7:0] ALU_ADDU  = 8'b0010_0001;
    localparam logic [7:0] ALU_SUBU  = 8'b0010_0011;
    localparam logic [7:0] ALU_SLT   = 8'b0010_1010;
    localparam logic [7:0] ALU_SLTU  = 8'b0010_1011;
    localparam logic [7:0] ALU_MULT  = 8'b0001_1000;
    localparam logic [7:0] ALU_MULTU = 8'b0001_1001;
    localparam logic [7:0] ALU_DIV   = 8'b0001_1010;
    localparam logic [7:0] ALU_DIVU  = 8'b0001_1011;
    localparam logic [7:0] ALU_MFHI  = 8'b0001_0000;
    localparam logic [7:0] ALU_MTHI  = 8'b0001_0001;
    localparam logic [7:0] ALU_MFLO  = 8'b0001_0010;
    localparam logic [7:0] ALU_MTLO  = 8'b0001_0011;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'b00,
        DIV_BUSY  = 2'b01,
        DIV_DZERO = 2'b10,
        DIV_DONE  = 2'b11
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, signs applied to the final result.
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               cancel,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e        state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  rem_r, quo_r, dvs_r;
    logic              neg_q_r, neg_r_r;

    logic              op1_neg_s, op2_neg_s, divisor_zero_s;
    logic [WIDTH-1:0]  op1_mag_s, op2_mag_s;
    logic [WIDTH:0]    partial_s, diff_s;
    logic [WIDTH-1:0]  step_rem_s;
    logic              step_bit_s;

    // Operand magnitudes and sign bookkeeping at issue
    always_comb begin
        op1_neg_s      = signed_div & opdata1[WIDTH-1];
        op2_neg_s      = signed_div & opdata2[WIDTH-1];
        op1_mag_s      = op1_neg_s ? -opdata1 : opdata1;
        op2_mag_s      = op2_neg_s ? -opdata2 : opdata2;
        divisor_zero_s = (opdata2 == {WIDTH{1'b0}});
    end

    // One restoring step: shift the next dividend bit in, subtract if it fits
    always_comb begin
        partial_s = {rem_r, quo_r[WIDTH-1]};
        diff_s    = partial_s - {1'b0, dvs_r};
        if (!diff_s[WIDTH]) begin
            step_rem_s = diff_s[WIDTH-1:0];
            step_bit_s = 1'b1;
        end else begin
            step_rem_s = partial_s[WIDTH-1:0];
            step_bit_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; cancel always returns to IDLE, DONE lasts one cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (start && !cancel) begin
                    state_next_s = divisor_zero_s ? DIV_DZERO : DIV_BUSY;
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (cancel) begin
                    state_next_s = DIV_IDLE;
                end else if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_next_s = DIV_DONE;
                end else begin
                    state_next_s = DIV_BUSY;
                end
            end
            DIV_DZERO: begin
                if (cancel) begin
                    state_next_s = DIV_IDLE;
                end else begin
                    state_next_s = DIV_DONE;
                end
            end
            DIV_DONE: state_next_s = DIV_IDLE;
            default:  state_next_s = DIV_IDLE;
        endcase
    end

    // Operand latch at issue (divide-by-zero result preloaded) and iteration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (start && !cancel) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (divisor_zero_s) begin
                            rem_r   <= opdata1;
                            quo_r   <= {WIDTH{1'b1}};
                            dvs_r   <= {WIDTH{1'b0}};
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                        end else begin
                            rem_r   <= {WIDTH{1'b0}};
                            quo_r   <= op1_mag_s;
                            dvs_r   <= op2_mag_s;
                            neg_q_r <= op1_neg_s ^ op2_neg_s;
                            neg_r_r <= op1_neg_s;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem_r <= step_rem_s;
                    quo_r <= {quo_r[WIDTH-2:0], step_bit_s};
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Result is only offered in DONE and is suppressed by a same-cycle cancel
    always_comb begin
        ready  = (state_r == DIV_DONE) && !cancel;
        result = {(neg_r_r ? -rem_r : rem_r), (neg_q_r ? -quo_r : quo_r)};
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: combinational ALU, multiplier, HI/LO forwarding and
// the iterative divider that stalls the front of the pipe.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       aluop,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [4:0]       dest_addr_i,
    input  logic             wreg_i,
    input  logic             flush,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] mem_hi,
    input  logic [WIDTH-1:0] mem_lo,
    input  logic             mem_whilo,
    input  logic [WIDTH-1:0] wb_hi,
    input  logic [WIDTH-1:0] wb_lo,
    input  logic             wb_whilo,
    output logic [4:0]       ex_dest_addr,
    output logic             ex_wreg,
    output logic [WIDTH-1:0] ex_dest_data,
    output logic [WIDTH-1:0] ex_hi,
    output logic [WIDTH-1:0] ex_lo,
    output logic             ex_whilo,
    output logic             stallreq
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   hi_fwd_s, lo_fwd_s;
    logic [2*WIDTH-1:0] mul_a_s, mul_b_s, prod_s;
    logic [SH_W-1:0]    shamt_s;
    logic               div_op_s, div_ready_s;
    logic [2*WIDTH-1:0] div_res_s;
    logic [WIDTH-1:0]   data_s, hi_s, lo_s;
    logic               wreg_s, whilo_s, stall_s;

    div_unit #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_op_s),
        .signed_div (aluop == ALU_DIV),
        .opdata1    (reg1),
        .opdata2    (reg2),
        .cancel     (flush),
        .result     (div_res_s),
        .ready      (div_ready_s)
    );

    // HI/LO forwarding: the youngest in-flight write wins
    always_comb begin
        if (mem_whilo) begin
            hi_fwd_s = mem_hi;
            lo_fwd_s = mem_lo;
        end else if (wb_whilo) begin
            hi_fwd_s = wb_hi;
            lo_fwd_s = wb_lo;
        end else begin
            hi_fwd_s = hi_i;
            lo_fwd_s = lo_i;
        end
    end

    // Operands extended to 2*WIDTH so one multiplier serves MULT and MULTU
    always_comb begin
        if (aluop == ALU_MULT) begin
            mul_a_s = {{WIDTH{reg1[WIDTH-1]}}, reg1};
            mul_b_s = {{WIDTH{reg2[WIDTH-1]}}, reg2};
        end else begin
            mul_a_s = {{WIDTH{1'b0}}, reg1};
            mul_b_s = {{WIDTH{1'b0}}, reg2};
        end
        prod_s   = mul_a_s * mul_b_s;
        shamt_s  = reg1[SH_W-1:0];
        div_op_s = is_div_op(aluop);
        stall_s  = div_op_s && !div_ready_s && !flush;
    end

    // ALU and HI/LO result selection
    always_comb begin
        data_s  = {WIDTH{1'b0}};
        hi_s    = {WIDTH{1'b0}};
        lo_s    = {WIDTH{1'b0}};
        wreg_s  = wreg_i;
        whilo_s = 1'b0;
        case (aluop)
            ALU_OR:   data_s = reg1 | reg2;
            ALU_AND:  data_s = reg1 & reg2;
            ALU_XOR:  data_s = reg1 ^ reg2;
            ALU_NOR:  data_s = ~(reg1 | reg2);
            ALU_SLL:  data_s = reg2 << shamt_s;
            ALU_SRL:  data_s = reg2 >> shamt_s;
            ALU_SRA:  data_s = WIDTH'($signed(reg2) >>> shamt_s);
            ALU_ADDU: data_s = reg1 + reg2;
            ALU_SUBU: data_s = reg1 - reg2;
            ALU_SLT:  data_s = {{(WIDTH-1){1'b0}}, ($signed(reg1) < $signed(reg2))};
            ALU_SLTU: data_s = {{(WIDTH-1){1'b0}}, (reg1 < reg2)};
            ALU_MFHI: data_s = hi_fwd_s;
            ALU_MFLO: data_s = lo_fwd_s;
            ALU_MULT, ALU_MULTU: begin
                hi_s    = prod_s[2*WIDTH-1:WIDTH];
                lo_s    = prod_s[WIDTH-1:0];
                wreg_s  = 1'b0;
                whilo_s = 1'b1;
            end
            ALU_MTHI: begin
                hi_s    = reg1;
                lo_s    = lo_fwd_s;
                whilo_s = 1'b1;
            end
            ALU_MTLO: begin
                hi_s    = hi_fwd_s;
                lo_s    = reg1;
                whilo_s = 1'b1;
            end
            ALU_DIV, ALU_DIVU: begin
                if (div_ready_s) begin
                    hi_s    = div_res_s[2*WIDTH-1:WIDTH];
                    lo_s    = div_res_s[WIDTH-1:0];
                    whilo_s = 1'b1;
                end else begin
                    whilo_s = 1'b0;
                end
            end
            default: data_s = {WIDTH{1'b0}};
        endcase
    end

    // Reset forces every output low immediately, independent of the clock
    always_comb begin
        if (!rst) begin
            ex_dest_addr = NOP_REG_ADDR;
            ex_wreg      = 1'b0;
            ex_dest_data = {WIDTH{1'b0}};
            ex_hi        = {WIDTH{1'b0}};
            ex_lo        = {WIDTH{1'b0}};
            ex_whilo     = 1'b0;
            stallreq     = 1'b0;
        end else begin
            ex_dest_addr = dest_addr_i;
            ex_wreg      = wreg_s;
            ex_dest_data = data_s;
            ex_hi        = hi_s;
            ex_lo        = lo_s;
            ex_whilo     = whilo_s;
            stallreq     = stall_s;
        end
    end

endmodule
